// File: rtl/traffic_intersection_ctrl.sv
// Round-robin intersection controller: ALLRED -> GREEN -> YELLOW per approach,
// with pedestrian walk extension and an emergency all-red preempt.
module traffic_intersection_ctrl #(
    parameter int NUM_DIR    = 2,
    parameter int GREEN_CYC  = 8,
    parameter int YELLOW_CYC = 3,
    parameter int ALLRED_CYC = 2,
    parameter int PED_CYC    = 12,
    parameter int CNT_W      = 8,
    localparam int DIR_W     = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NUM_DIR-1:0]     ped_req,
    input  logic                   emerg,
    output logic [2*NUM_DIR-1:0]   lights,
    output logic [NUM_DIR-1:0]     walk,
    output logic [DIR_W-1:0]       active_dir,
    output logic                   emerg_active
);

    typedef enum logic [1:0] {
        ST_ALLRED,
        ST_GREEN,
        ST_YELLOW,
        ST_EMERG
    } state_t;

    localparam int PED_DUR = (PED_CYC > GREEN_CYC) ? PED_CYC : GREEN_CYC;

    // Timers compare against duration-1 so a duration of 2^CNT_W still fits.
    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] PED_LAST    = CNT_W'(PED_DUR - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_CYC - 1);
    localparam logic [DIR_W-1:0] LAST_DIR    = DIR_W'(NUM_DIR - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     timer_q, timer_d;
    logic [DIR_W-1:0]     dir_q, dir_d;
    logic [NUM_DIR-1:0]   pending_q, pending_d;
    logic [2*NUM_DIR-1:0] lights_q, lights_d;
    logic [NUM_DIR-1:0]   walk_q, walk_d;
    logic                 emerg_active_q, emerg_active_d;

    logic [DIR_W-1:0]     next_dir;
    logic [CNT_W-1:0]     timer_inc;
    logic [CNT_W-1:0]     green_last;

    assign next_dir   = (dir_q == LAST_DIR) ? '0 : dir_q + DIR_W'(1);
    assign timer_inc  = timer_q + CNT_W'(1);
    // A walk in progress means this green was granted the pedestrian duration.
    assign green_last = (walk_q != '0) ? PED_LAST : GREEN_LAST;

    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        dir_d          = dir_q;
        pending_d      = pending_q;
        lights_d       = lights_q;
        walk_d         = walk_q;
        emerg_active_d = emerg_active_q;

        if (enable) begin
            pending_d = pending_q | ped_req;

            case (state_q)
                ST_ALLRED: begin
                    if (emerg) begin
                        state_d = ST_EMERG;
                        timer_d = '0;
                    end else if (timer_q == ALLRED_LAST) begin
                        state_d = ST_GREEN;
                        timer_d = '0;
                        dir_d   = next_dir;
                        walk_d  = '0;
                        if (pending_d[next_dir]) begin
                            walk_d[next_dir] = 1'b1;
                        end
                        pending_d[next_dir] = 1'b0;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
                ST_GREEN: begin
                    if (emerg || timer_q == green_last) begin
                        state_d = ST_YELLOW;
                        timer_d = '0;
                        walk_d  = '0;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
                ST_YELLOW: begin
                    if (timer_q == YELLOW_LAST) begin
                        state_d = emerg ? ST_EMERG : ST_ALLRED;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
                ST_EMERG: begin
                    if (!emerg) begin
                        state_d = ST_ALLRED;
                        timer_d = '0;
                    end
                end
                default: begin
                    state_d = ST_ALLRED;
                    timer_d = '0;
                    walk_d  = '0;
                end
            endcase

            // Outputs are decoded from the next state so they register with it.
            lights_d = '0;
            for (int d = 0; d < NUM_DIR; d++) begin
                if (DIR_W'(d) == dir_d) begin
                    if (state_d == ST_GREEN) begin
                        lights_d[2*d +: 2] = 2'b01;
                    end else if (state_d == ST_YELLOW) begin
                        lights_d[2*d +: 2] = 2'b10;
                    end
                end
            end
            emerg_active_d = (state_d == ST_EMERG);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_ALLRED;
            timer_q        <= '0;
            dir_q          <= LAST_DIR;
            pending_q      <= '0;
            lights_q       <= '0;
            walk_q         <= '0;
            emerg_active_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            dir_q          <= dir_d;
            pending_q      <= pending_d;
            lights_q       <= lights_d;
            walk_q         <= walk_d;
            emerg_active_q <= emerg_active_d;
        end
    end

    assign lights       = lights_q;
    assign walk         = walk_q;
    assign active_dir   = dir_q;
    assign emerg_active = emerg_active_q;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Table-driven bench for traffic_intersection_ctrl at default parameters:
// cycle-by-cycle expected outputs plus an asynchronous mid-green reset.
module tb_traffic_intersection_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [1:0] ped_req;
    logic       emerg;
    logic [3:0] lights;
    logic [1:0] walk;
    logic       active_dir;
    logic       emerg_active;

    always #5 clk = ~clk;

    traffic_intersection_ctrl #(
        .NUM_DIR   (2),
        .GREEN_CYC (8),
        .YELLOW_CYC(3),
        .ALLRED_CYC(2),
        .PED_CYC   (12),
        .CNT_W     (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .ped_req     (ped_req),
        .emerg       (emerg),
        .lights      (lights),
        .walk        (walk),
        .active_dir  (active_dir),
        .emerg_active(emerg_active)
    );

    typedef struct {
        logic       en;
        logic [1:0] ped;
        logic       em;
        logic [3:0] exp_lights;
        logic [1:0] exp_walk;
        logic       exp_dir;
        logic       exp_ea;
    } vec_t;

    vec_t vecs[$];
    int   vectorCount = 0;
    int   missCount   = 0;

    task automatic addRows(input int n, input logic en, input logic [1:0] ped, input logic em,
                           input logic [3:0] l, input logic [1:0] w, input logic d, input logic ea);
        vec_t v;
        v.en = en; v.ped = ped; v.em = em;
        v.exp_lights = l; v.exp_walk = w; v.exp_dir = d; v.exp_ea = ea;
        repeat (n) vecs.push_back(v);
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] l, input logic [1:0] w,
                               input logic d, input logic ea);
        vectorCount++;
        if (lights !== l) begin
            missCount++;
            $display("[TB] FAIL %s lights got %b want %b", tag, lights, l);
        end
        if (walk !== w) begin
            missCount++;
            $display("[TB] FAIL %s walk got %b want %b", tag, walk, w);
        end
        if (active_dir !== d) begin
            missCount++;
            $display("[TB] FAIL %s active_dir got %b want %b", tag, active_dir, d);
        end
        if (emerg_active !== ea) begin
            missCount++;
            $display("[TB] FAIL %s emerg_active got %b want %b", tag, emerg_active, ea);
        end
    endtask

    task automatic applyStimulus(input int idx);
        enable  = vecs[idx].en;
        ped_req = vecs[idx].ped;
        emerg   = vecs[idx].em;
        @(posedge clk);
        #1;
        checkOutput($sformatf("vec%0d", idx), vecs[idx].exp_lights, vecs[idx].exp_walk,
                    vecs[idx].exp_dir, vecs[idx].exp_ea);
    endtask

    // Per-cycle safety invariants on the light encoding and walk consistency.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            int nonRed;
            nonRed = 0;
            for (int d = 0; d < 2; d++) begin
                if (lights[2*d +: 2] === 2'b11) begin
                    missCount++;
                    $display("[TB] FAIL enc11 dir%0d lights got %b want not 11", d, lights);
                end
                if (lights[2*d +: 2] !== 2'b00) nonRed++;
                if (walk[d] === 1'b1 && lights[2*d +: 2] !== 2'b01) begin
                    missCount++;
                    $display("[TB] FAIL walkgreen dir%0d lights got %b want 01 while walking", d, lights);
                end
            end
            if (nonRed > 1) begin
                missCount++;
                $display("[TB] FAIL onehot lights got %b want at most one non-red", lights);
            end
        end
    end

    int split;

    initial begin
        reset   = 1'b1;
        enable  = 1'b0;
        ped_req = 2'b00;
        emerg   = 1'b0;

        // Baseline rotation: dir0 then dir1 with plain timing.
        addRows(1, 1, 2'b00, 0, 4'b0000, 2'b00, 1, 0);
        addRows(8, 1, 2'b00, 0, 4'b0001, 2'b00, 0, 0);
        addRows(3, 1, 2'b00, 0, 4'b0010, 2'b00, 0, 0);
        addRows(2, 1, 2'b00, 0, 4'b0000, 2'b00, 0, 0);
        addRows(8, 1, 2'b00, 0, 4'b0100, 2'b00, 1, 0);
        addRows(3, 1, 2'b00, 0, 4'b1000, 2'b00, 1, 0);
        addRows(2, 1, 2'b00, 0, 4'b0000, 2'b00, 1, 0);
        // Pedestrian pulse for dir1 during dir0 green: one 12-cycle walk green, then normal.
        addRows(1, 1, 2'b00, 0, 4'b0001, 2'b00, 0, 0);
        addRows(1, 1, 2'b10, 0, 4'b0001, 2'b00, 0, 0);
        addRows(6, 1, 2'b00, 0, 4'b0001, 2'b00, 0, 0);
        addRows(3, 1, 2'b00, 0, 4'b0010, 2'b00, 0, 0);
        addRows(2, 1, 2'b00, 0, 4'b0000, 2'b00, 0, 0);
        addRows(12, 1, 2'b00, 0, 4'b0100, 2'b10, 1, 0);
        addRows(3, 1, 2'b00, 0, 4'b1000, 2'b00, 1, 0);
        addRows(2, 1, 2'b00, 0, 4'b0000, 2'b00, 1, 0);
        addRows(8, 1, 2'b00, 0, 4'b0001, 2'b00, 0, 0);
        addRows(3, 1, 2'b00, 0, 4'b0010, 2'b00, 0, 0);
        addRows(2, 1, 2'b00, 0, 4'b0000, 2'b00, 0, 0);
        addRows(8, 1, 2'b00, 0, 4'b0100, 2'b00, 1, 0);
        addRows(3, 1, 2'b00, 0, 4'b1000, 2'b00, 1, 0);
        addRows(2, 1, 2'b00, 0, 4'b0000, 2'b00, 1, 0);
        // Emergency raised in the third cycle of dir0 green.
        addRows(3, 1, 2'b00, 0, 4'b0001, 2'b00, 0, 0);
        addRows(3, 1, 2'b00, 1, 4'b0010, 2'b00, 0, 0);
        addRows(5, 1, 2'b00, 1, 4'b0000, 2'b00, 0, 1);
        addRows(2, 1, 2'b00, 0, 4'b0000, 2'b00, 0, 0);
        addRows(8, 1, 2'b00, 0, 4'b0100, 2'b00, 1, 0);
        // Enable dropped mid-yellow with ped_req[0] toggling; no capture while frozen.
        addRows(1, 1, 2'b00, 0, 4'b1000, 2'b00, 1, 0);
        addRows(1, 0, 2'b01, 0, 4'b1000, 2'b00, 1, 0);
        addRows(1, 0, 2'b00, 0, 4'b1000, 2'b00, 1, 0);
        addRows(1, 0, 2'b01, 0, 4'b1000, 2'b00, 1, 0);
        addRows(1, 0, 2'b00, 0, 4'b1000, 2'b00, 1, 0);
        addRows(2, 1, 2'b00, 0, 4'b1000, 2'b00, 1, 0);
        addRows(2, 1, 2'b00, 0, 4'b0000, 2'b00, 1, 0);
        // dir0 green without walk; a request during it stays pending for later.
        addRows(1, 1, 2'b00, 0, 4'b0001, 2'b00, 0, 0);
        addRows(1, 1, 2'b01, 0, 4'b0001, 2'b00, 0, 0);
        addRows(6, 1, 2'b00, 0, 4'b0001, 2'b00, 0, 0);
        addRows(3, 1, 2'b00, 0, 4'b0010, 2'b00, 0, 0);
        addRows(2, 1, 2'b00, 0, 4'b0000, 2'b00, 0, 0);
        addRows(3, 1, 2'b00, 0, 4'b0100, 2'b00, 1, 0);
        split = vecs.size();
        // After the mid-green reset: pending[0] gone, then a same-edge request for dir1.
        addRows(1, 1, 2'b00, 0, 4'b0000, 2'b00, 1, 0);
        addRows(8, 1, 2'b00, 0, 4'b0001, 2'b00, 0, 0);
        addRows(3, 1, 2'b00, 0, 4'b0010, 2'b00, 0, 0);
        addRows(2, 1, 2'b00, 0, 4'b0000, 2'b00, 0, 0);
        addRows(1, 1, 2'b10, 0, 4'b0100, 2'b10, 1, 0);
        addRows(11, 1, 2'b00, 0, 4'b0100, 2'b10, 1, 0);
        addRows(3, 1, 2'b00, 0, 4'b1000, 2'b00, 1, 0);

        #12;
        checkOutput("reset_state", 4'b0000, 2'b00, 1, 0);
        @(negedge clk);
        reset  = 1'b0;
        enable = 1'b1;

        for (int i = 0; i < split; i++) applyStimulus(i);

        // Asynchronous reset in the middle of dir1 green.
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset", 4'b0000, 2'b00, 1, 0);
        @(posedge clk);
        #1;
        checkOutput("reset_held", 4'b0000, 2'b00, 1, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = split; i < vecs.size(); i++) applyStimulus(i);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/traffic_intersection_ctrl.md
TRAFFIC_INTERSECTION_CTRL -- requirements
Module: traffic_intersection_ctrl

Interface
REQ-001 Parameter NUM_DIR, 2, number of approaches served round-robin (legal range 2..4).
REQ-002 Parameter GREEN_CYC, 8, base green duration in enabled clock cycles.
REQ-003 Parameter YELLOW_CYC, 3, yellow duration in enabled clock cycles.
REQ-004 Parameter ALLRED_CYC, 2, all-red clearance duration in enabled clock cycles.
REQ-005 Parameter PED_CYC, 12, minimum green duration when a pedestrian walk is granted.
REQ-006 Parameter CNT_W, 8, phase timer width; every duration SHALL be between 1 and 2^CNT_W inclusive.
REQ-007 clk  input  1  clock, all state updates on the rising edge.
REQ-008 reset  input  1  reset, asynchronous, active-high.
REQ-009 enable  input  1  high = run; low = freeze timer, state and all outputs.
REQ-010 ped_req  input  NUM_DIR  per-approach pedestrian request, sampled every cycle.
REQ-011 emerg  input  1  emergency preempt level; high forces all-red hold.
REQ-012 lights  output  2*NUM_DIR  per-approach light, bits [2d+1:2d] = approach d; 00 red, 01 green, 10 yellow; 11 never driven.
REQ-013 walk  output  NUM_DIR  walk indication per approach.
REQ-014 active_dir  output  max(1,clog2(NUM_DIR))  approach currently or most recently served.
REQ-015 emerg_active  output  1  high while in the EMERG state.

Function
REQ-016 The FSM SHALL have the states ALLRED, GREEN, YELLOW and EMERG, and all outputs SHALL be registered.
REQ-017 Each timed state SHALL last exactly its duration in enabled cycles: the timer clears on entry and exits when timer == duration-1.
REQ-018 ALLRED->GREEN: active_dir SHALL increment, wrapping from NUM_DIR-1 to 0, and lights[active_dir] SHALL become 01.
REQ-019 GREEN->YELLOW on expiry; YELLOW->ALLRED on expiry.
REQ-020 At most one approach SHALL be non-red in any cycle; all other approaches SHALL read 00.
REQ-021 Pending register: pending[d] |= ped_req[d] every enabled cycle, and pending[d] SHALL be cleared on the GREEN-entry edge for approach d.
REQ-022 A request present on the same edge as GREEN entry for d SHALL be served in that green.
REQ-023 If pending[d] (including a same-edge request) is set at GREEN entry for d, walk[d] SHALL be high for the whole GREEN, and the green duration SHALL be max(GREEN_CYC, PED_CYC); otherwise the duration is GREEN_CYC.
REQ-024 A request for d raised during d's own GREEN SHALL stay pending until d's next green.
REQ-025 walk SHALL be 0 in YELLOW, ALLRED and EMERG.
REQ-026 emerg high while in GREEN: the next state SHALL be YELLOW with the timer cleared, and walk SHALL drop on that edge.
REQ-027 emerg high in YELLOW: yellow SHALL complete, then go to EMERG instead of ALLRED.
REQ-028 emerg high in ALLRED: the next state SHALL be EMERG.
REQ-029 In EMERG, all lights SHALL be 00, emerg_active SHALL be 1, and the state SHALL be held while emerg is high.
REQ-030 On emerg low, EMERG->ALLRED with a full ALLRED_CYC clearance, then green for the next approach after active_dir.
REQ-031 Pending requests SHALL be retained through EMERG.
REQ-032 enable low SHALL take precedence over all inputs except reset, with no request capture while low.
REQ-033 enable SHALL NOT affect the asynchronous reset.

Reset
REQ-034 On reset assertion, the block SHALL immediately set: state ALLRED, timer 0, active_dir NUM_DIR-1, pending 0, lights all 00, walk 0, emerg_active 0.
REQ-035 Reset asserted mid-phase SHALL abort the phase with no yellow.
REQ-036 After reset release with enable high, approach 0 SHALL turn green after exactly ALLRED_CYC rising edges.

Verification (defaults, NUM_DIR=2)
REQ-037 Reset release, enable=1, no requests -> dir0 green after 2 edges; green 8, yellow 3, all-red 2; then dir1 green; then back to dir0.
REQ-038 ped_req[1] pulsed one cycle during dir0 green -> dir1 green lasts 12 cycles with walk[1]=1 throughout; the following dir1 green lasts 8 cycles with walk[1]=0.
REQ-039 emerg raised at cycle 3 of dir0 green -> yellow on the next edge, 3 yellow cycles, then EMERG with all red; hold 5 cycles; drop emerg -> 2 all-red cycles, then dir1 green.
REQ-040 enable low for 4 cycles mid-yellow, with ped_req[0] toggling during that time -> lights and timer frozen; yellow resumes with its remaining count; pending[0] stays 0.
REQ-041 Reset asserted during dir1 green with pending[0] set -> lights 00 asynchronously; pending cleared; after release, dir0 green after 2 edges, 8 cycles long, walk 0.
REQ-042 Every cycle, assert: no 11 encoding, at most one non-red approach, and walk[d] implies lights[d]==01.
